// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and port indices.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the CPU and DMA ports.
// DMEM_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise port 0 always wins.
import dmem_arb_pkg::*;

module dmem_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    grant = PORT_CPU;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    if (req0 && req1) begin
      grant = ~last_grant;
    end else if (req1) begin
      grant = PORT_DMA;
    end
`else
    if (!req0 && req1) begin
      grant = PORT_DMA;
    end
`endif
  end

`ifndef DMEM_ARB_ROUND_ROBIN_EN
  // Fixed priority has no use for the grant history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM with port-1 write protection.
// Build option: DMEM_ARB_ROUND_ROBIN_EN enables round-robin arbitration.
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(8'hF0)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e              state;
  logic                cmd_we;
  logic                cmd_port;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic                grant;
  logic                grant_valid;
  logic                last_grant;
  logic                blocked;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Priority pointer: the port that wins the next tie.
  logic rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= PORT_CPU;
    end else if (state == IDLE && grant_valid) begin
      rr_ptr <= ~grant;
    end
  end

  assign last_grant = ~rr_ptr;
`else
  assign last_grant = PORT_DMA;
`endif

  dmem_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .grant      (grant),
    .valid      (grant_valid)
  );

  assign blocked = (cmd_port == PORT_DMA) && cmd_we && (cmd_addr >= PROT_BASE);

  // Write enable decoded from the state register so reset kills it immediately.
  assign mem_we    = (state == ACCESS) && cmd_we && !blocked;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_we    <= 1'b0;
      cmd_port  <= PORT_CPU;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err1      <= 1'b0;
      rdata     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            state     <= ACCESS;
            cmd_port  <= grant;
            cmd_we    <= (grant == PORT_DMA) ? we1 : we0;
            cmd_addr  <= (grant == PORT_DMA) ? addr1 : addr0;
            cmd_wdata <= (grant == PORT_DMA) ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          state <= DONE;
          ack0  <= (cmd_port == PORT_CPU);
          ack1  <= (cmd_port == PORT_DMA);
          err1  <= blocked;
          if (!cmd_we) begin
            rdata <= mem_rdata;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of arbitration, protection and memory contents.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1, err1, mem_we, busy;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] ram [256];
  bit         ram_ready = 1'b0;
  int         we_cnt = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester intent and reference model state
  bit         r_req [2];
  bit         r_we  [2];
  logic [7:0] r_addr[2];
  logic [7:0] r_data[2];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rdata;
  bit         prio;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .err1      (err1),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  function automatic logic [7:0] init_val(int i);
    return 8'(i * 37 + 11);
  endfunction

  // Behavioural RAM attached to the arbiter
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    req0 = r_req[0]; we0 = r_we[0]; addr0 = r_addr[0]; wdata0 = r_data[0];
    req1 = r_req[1]; we1 = r_we[1]; addr1 = r_addr[1]; wdata1 = r_data[1];
  endtask

  task automatic set_req(input int p, input bit w, input logic [7:0] a, input logic [7:0] d);
    r_req[p] = 1'b1; r_we[p] = w; r_addr[p] = a; r_data[p] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    apply();
    prio = 1'b0;
    exp_rdata = 8'h00;
    @(negedge clk);
    chk("rst_busy",   32'(busy),      32'd0);
    chk("rst_mem_we", 32'(mem_we),    32'd0);
    chk("rst_ack0",   32'(ack0),      32'd0);
    chk("rst_ack1",   32'(ack1),      32'd0);
    chk("rst_err1",   32'(err1),      32'd0);
    chk("rst_rdata",  32'(rdata),     32'd0);
    chk("rst_maddr",  32'(mem_addr),  32'd0);
    chk("rst_mwdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;
  endtask

  // One arbitration round starting at a negedge in IDLE, ending at the next IDLE negedge.
  task automatic arb_cycle(input bit drop, input bit pulse1);
    bit         w, cw, blk;
    logic [7:0] ca, cd, rd;
    chk("idle_busy", 32'(busy), 32'd0);
    if (!r_req[0] && !r_req[1]) begin
      @(negedge clk);
      return;
    end
    if (r_req[0] && r_req[1]) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      w = prio;
`else
      w = 1'b0;
`endif
    end else begin
      w = r_req[1];
    end
    cw = r_we[w]; ca = r_addr[w]; cd = r_data[w];
    blk = w && cw && (ca >= 8'hF0);
    @(negedge clk);
    chk("acc_busy",   32'(busy),     32'd1);
    chk("acc_mem_we", 32'(mem_we),   32'(cw && !blk));
    chk("acc_maddr",  32'(mem_addr), 32'(ca));
    chk("acc_ack",    32'({ack1, ack0}), 32'd0);
    if (cw) chk("acc_mwdata", 32'(mem_wdata), 32'(cd));
    // Accepted command must be immune to input changes
    if (w) begin
      we1 = 1'($urandom); addr1 = 8'($urandom); wdata1 = 8'($urandom);
    end else begin
      we0 = 1'($urandom); addr0 = 8'($urandom); wdata0 = 8'($urandom);
    end
    if (pulse1) req1 = 1'b1;
    rd = cw ? exp_rdata : ref_mem[ca];
    if (cw && !blk) ref_mem[ca] = cd;
    exp_rdata = rd;
    prio = !w;
    @(negedge clk);
    chk("done_ack0",   32'(ack0),   32'(!w));
    chk("done_ack1",   32'(ack1),   32'(w));
    chk("done_err1",   32'(err1),   32'(blk));
    chk("done_rdata",  32'(rdata),  32'(exp_rdata));
    chk("done_mem_we", 32'(mem_we), 32'd0);
    if (drop) r_req[w] = 1'b0;
    apply();
    @(negedge clk);
  endtask

  initial begin
    int         we_base, bad;
    logic [7:0] old;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = 8'h00; r_data[p] = 8'h00;
    end
    apply();
    do_reset();

    // Port-0 write then read back
    we_base = we_cnt;
    set_req(0, 1'b1, 8'h10, 8'hA5); apply(); arb_cycle(1'b1, 1'b0);
    set_req(0, 1'b0, 8'h10, 8'h00); apply(); arb_cycle(1'b1, 1'b0);
    chk("wr_rd_rdata", 32'(rdata), 32'h0A5);
    chk("wr_rd_we_cycles", 32'(we_cnt - we_base), 32'd1);

    // Protected region: blocked write at F0, allowed write at EF
    old = ref_mem[8'hF0];
    we_base = we_cnt;
    set_req(1, 1'b1, 8'hF0, 8'h55); apply(); arb_cycle(1'b1, 1'b0);
    chk("prot_no_we", 32'(we_cnt - we_base), 32'd0);
    set_req(0, 1'b0, 8'hF0, 8'h00); apply(); arb_cycle(1'b1, 1'b0);
    chk("prot_old_val", 32'(rdata), 32'(old));
    set_req(1, 1'b1, 8'hEF, 8'h66); apply(); arb_cycle(1'b1, 1'b0);
    set_req(1, 1'b0, 8'hEF, 8'h00); apply(); arb_cycle(1'b1, 1'b0);
    chk("unprot_val", 32'(rdata), 32'h066);

    // Both ports requesting reads continuously from reset
    do_reset();
    set_req(0, 1'b0, 8'h10, 8'h00);
    set_req(1, 1'b0, 8'hF0, 8'h00);
    apply();
    for (int k = 0; k < 6; k++) arb_cycle(1'b0, 1'b0);
    r_req[0] = 1'b0; r_req[1] = 1'b0; apply();
    arb_cycle(1'b1, 1'b0);
    chk("withdrawn_busy", 32'(busy), 32'd0);

    // Reset in the ACCESS cycle of a write aborts it
    set_req(0, 1'b1, 8'h20, 8'hFF); apply();
    @(negedge clk);
    chk("abort_we_before", 32'(mem_we), 32'd1);
    rst = 1'b1;
    r_req[0] = 1'b0; apply();
    #1;
    chk("abort_we",   32'(mem_we), 32'd0);
    chk("abort_busy", 32'(busy),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    prio = 1'b0;
    exp_rdata = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_ack", 32'({ack1, ack0}), 32'd0);
    end
    chk("abort_ram20", 32'(ram[8'h20]), 32'(ref_mem[8'h20]));

    // Short req1 pulse while busy is never granted
    set_req(0, 1'b0, 8'h20, 8'h00); apply(); arb_cycle(1'b1, 1'b1);
    arb_cycle(1'b1, 1'b0);
    chk("pulse_no_ack1", 32'(ack1), 32'd0);
    chk("pulse_idle",    32'(busy), 32'd0);

    // Randomized traffic; losers keep requesting until served
    for (int k = 0; k < 60; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!r_req[p] && $urandom_range(0, 2) != 0) begin
          set_req(p, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hE8, 8'hFF)) : 8'($urandom),
                  8'($urandom));
        end
      end
      apply();
      arb_cycle(1'b1, 1'b0);
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("ram_final", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
